// File: rtl/de2i150_io_pkg.sv
// Shared types and constants for the DE2i-150 input sampler.
// Event encoding, key/switch counts and debounce length helper.
package de2i150_io_pkg;

  localparam int NUM_KEYS = 4;
  localparam int NUM_SW = 18;

  localparam logic EVT_PRESS = 1'b1;
  localparam logic EVT_RELEASE = 1'b0;

  typedef struct packed {
    logic       kind;
    logic [1:0] idx;
  } evt_t;

  function automatic int deb_cycles(
    input int clk_hz,
    input int ms
  );
    return clk_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/de2i150_debounce.sv
// One-bit synchronizer plus debouncer with registered edge strobes.
// INVERT flips polarity after the synchronizer (active-low keys).
module de2i150_debounce #(
  parameter int DEB_CYCLES = 8,
  parameter bit INVERT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW =
    (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(DEB_CYCLES - 1);
  localparam logic RST_V = INVERT;

  logic          meta;
  logic          sync;
  logic          s;
  logic [CW-1:0] cnt;

  assign s = sync ^ INVERT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta  <= RST_V;
      sync  <= RST_V;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
      rise <= 1'b0;
      fall <= 1'b0;
      if (s == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= s;
        cnt   <= '0;
        rise  <= s;
        fall  <= ~s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/de2i150_input_sampler.sv
// Debounced keys/switches with edge pulses and a 4-deep
// key event FIFO behind a valid/ready handshake.
module de2i150_input_sampler
  import de2i150_io_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int DEBOUNCE_MS = 10,
  parameter int DEB_CYCLES =
    deb_cycles(CLK_HZ, DEBOUNCE_MS)
) (
  input  logic        CLOCK_50,
  input  logic        RST_N,
  input  logic [3:0]  KEY,
  input  logic [17:0] SW,
  output logic [3:0]  key_level,
  output logic [3:0]  key_press,
  output logic [3:0]  key_release,
  output logic [17:0] sw_level,
  output logic        sw_changed,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [2:0]  evt_data,
  output logic        evt_ovf,
  input  logic        ovf_clr
);

  logic [NUM_SW-1:0] sw_rise;
  logic [NUM_SW-1:0] sw_fall;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    de2i150_debounce #(
      .DEB_CYCLES(DEB_CYCLES),
      .INVERT(1'b1)
    ) u_deb (
      .clk  (CLOCK_50),
      .rst_n(RST_N),
      .raw  (KEY[i]),
      .level(key_level[i]),
      .rise (key_press[i]),
      .fall (key_release[i])
    );
  end

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    de2i150_debounce #(
      .DEB_CYCLES(DEB_CYCLES),
      .INVERT(1'b0)
    ) u_deb (
      .clk  (CLOCK_50),
      .rst_n(RST_N),
      .raw  (SW[i]),
      .level(sw_level[i]),
      .rise (sw_rise[i]),
      .fall (sw_fall[i])
    );
  end

  assign sw_changed = |(sw_rise | sw_fall);

  logic [NUM_KEYS-1:0] pend_p;
  logic [NUM_KEYS-1:0] pend_r;
  logic [NUM_KEYS-1:0] gnt_p;
  logic [NUM_KEYS-1:0] gnt_r;
  logic                found;
  evt_t                pick;

  evt_t       mem [4];
  logic [2:0] wr_ptr;
  logic [2:0] rd_ptr;
  logic       empty;
  logic       full;
  logic       pop;
  logic       wr_en;
  logic       ovf_set;
  evt_t       head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = ((wr_ptr ^ rd_ptr) == 3'b100);
  assign pop   = !empty && evt_ready;
  assign wr_en = found && (!full || pop);
  assign head  = mem[rd_ptr[1:0]];

  assign evt_valid = !empty;
  assign evt_data  = empty ? 3'b000 : head;

  assign ovf_set = |(key_press & pend_p)
                 | |(key_release & pend_r);

  // Lowest key first; press outranks release within a key.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    gnt_p = '0;
    gnt_r = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (!found && pend_p[i]) begin
        found    = 1'b1;
        gnt_p[i] = 1'b1;
        pick     = '{kind: EVT_PRESS, idx: 2'(i)};
      end
      if (!found && pend_r[i]) begin
        found    = 1'b1;
        gnt_r[i] = 1'b1;
        pick     = '{kind: EVT_RELEASE, idx: 2'(i)};
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      pend_p  <= '0;
      pend_r  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      evt_ovf <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        mem[i] <= '0;
      end
    end else begin
      pend_p <= (pend_p & ~(wr_en ? gnt_p : '0))
              | key_press;
      pend_r <= (pend_r & ~(wr_en ? gnt_r : '0))
              | key_release;
      if (wr_en) begin
        mem[wr_ptr[1:0]] <= pick;
        wr_ptr <= wr_ptr + 3'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 3'd1;
      end
      if (ovf_set) begin
        evt_ovf <= 1'b1;
      end else if (ovf_clr) begin
        evt_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_de2i150_input_sampler.sv
// Directed + randomized bench for de2i150_input_sampler
// against a window/queue based reference model.
module tb_de2i150_input_sampler;
  import de2i150_io_pkg::*;

  localparam int DEB = 8;
  localparam int NB = 22;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  KEY;
  logic [17:0] SW;
  logic        evt_ready;
  logic        ovf_clr;
  logic [3:0]  key_level;
  logic [3:0]  key_press;
  logic [3:0]  key_release;
  logic [17:0] sw_level;
  logic        sw_changed;
  logic        evt_valid;
  logic [2:0]  evt_data;
  logic        evt_ovf;

  always #5 clk = ~clk;

  de2i150_input_sampler #(
    .CLK_HZ(1000),
    .DEBOUNCE_MS(8)
  ) dut (
    .CLOCK_50   (clk),
    .RST_N      (rst_n),
    .KEY        (KEY),
    .SW         (SW),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .sw_level   (sw_level),
    .sw_changed (sw_changed),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_data   (evt_data),
    .evt_ovf    (evt_ovf),
    .ovf_clr    (ovf_clr)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: bits 0..3 keys (1 = pressed), 4..21 switches.
  logic [NB-1:0]  m_lvl, m_rise, m_fall;
  logic [NB-1:0]  r1, r2;
  logic [DEB-1:0] win [NB];
  logic [3:0]     m_pp, m_pr;
  logic [2:0]     m_q [$];
  logic           m_ovf;

  task automatic model_reset();
    m_lvl = '0; m_rise = '0; m_fall = '0;
    r1 = '0; r2 = '0;
    for (int b = 0; b < NB; b++) win[b] = '0;
    m_pp = '0; m_pr = '0;
    m_q.delete();
    m_ovf = 1'b0;
  endtask

  task automatic model_edge();
    logic [3:0] kp, kr;
    logic [NB-1:0] s, raw;
    logic was_full, pop, have, oset;
    logic [2:0] ev;
    int gi;
    logic gk;
    kp = m_rise[3:0];
    kr = m_fall[3:0];
    was_full = (m_q.size() == 4);
    pop = (m_q.size() > 0) && evt_ready;
    have = 1'b0; ev = '0; gi = 0; gk = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!have && m_pp[i]) begin
        have = 1'b1; gi = i; gk = 1'b1;
        ev = {1'b1, 2'(i)};
      end
      if (!have && m_pr[i]) begin
        have = 1'b1; gi = i; gk = 1'b0;
        ev = {1'b0, 2'(i)};
      end
    end
    oset = |(kp & m_pp) || |(kr & m_pr);
    if (pop) void'(m_q.pop_front());
    if (have && (!was_full || pop)) begin
      m_q.push_back(ev);
      if (gk) m_pp[gi] = 1'b0;
      else m_pr[gi] = 1'b0;
    end
    m_pp = m_pp | kp;
    m_pr = m_pr | kr;
    if (oset) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    raw = {SW, ~KEY};
    s = r2; r2 = r1; r1 = raw;
    for (int b = 0; b < NB; b++) begin
      win[b] = {win[b][DEB-2:0], s[b]};
      m_rise[b] = 1'b0;
      m_fall[b] = 1'b0;
      if (win[b] == {DEB{~m_lvl[b]}}) begin
        m_lvl[b] = ~m_lvl[b];
        m_rise[b] = m_lvl[b];
        m_fall[b] = ~m_lvl[b];
      end
    end
  endtask

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [2:0] hd;
    hd = (m_q.size() > 0) ? m_q[0] : 3'b000;
    chk("key_level", 32'(key_level), 32'(m_lvl[3:0]));
    chk("key_press", 32'(key_press), 32'(m_rise[3:0]));
    chk("key_release", 32'(key_release),
        32'(m_fall[3:0]));
    chk("sw_level", 32'(sw_level), 32'(m_lvl[21:4]));
    chk("sw_changed", 32'(sw_changed),
        32'(|(m_rise[21:4] | m_fall[21:4])));
    chk("evt_valid", 32'(evt_valid),
        32'(m_q.size() > 0));
    chk("evt_data", 32'(evt_data), 32'(hd));
    chk("evt_ovf", 32'(evt_ovf), 32'(m_ovf));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    else model_reset();
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int nchg;

  initial begin
    KEY = 4'hF; SW = '0;
    evt_ready = 1'b0; ovf_clr = 1'b0;
    rst_n = 1'b0;
    model_reset();
    ticks(3);
    rst_n = 1'b1;
    ticks(2);

    // 1: single press latency and hold until ready
    KEY[2] = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (n == 9) chk("t1_lvl9", 32'(key_level[2]), 0);
      if (n == 10) begin
        chk("t1_press10", 32'(key_press[2]), 1);
        chk("t1_lvl10", 32'(key_level[2]), 1);
      end
      if (n == 11) chk("t1_valid11", 32'(evt_valid), 0);
      if (n == 12) begin
        chk("t1_valid12", 32'(evt_valid), 1);
        chk("t1_data12", 32'(evt_data), 32'h6);
      end
    end
    ticks(3);
    chk("t1_hold", 32'(evt_data), 32'h6);
    evt_ready = 1'b1;
    tick();
    chk("t1_pop", 32'(evt_valid), 0);
    KEY[2] = 1'b1;
    ticks(16);

    // 2: glitch shorter than debounce window
    KEY[0] = 1'b0;
    ticks(5);
    KEY[0] = 1'b1;
    ticks(15);
    chk("t2_lvl", 32'(key_level[0]), 0);
    chk("t2_valid", 32'(evt_valid), 0);

    // 3: simultaneous presses drain in index order
    KEY = 4'h0;
    for (int n = 1; n <= 15; n++) begin
      tick();
      if (n >= 12)
        chk("t3_order", 32'(evt_data), 32'(n - 8));
    end
    KEY = 4'hF;
    ticks(20);

    // 4: full FIFO, pending flags, overflow and clear
    evt_ready = 1'b0;
    KEY = 4'h0;
    ticks(12);
    KEY = 4'hF;
    ticks(16);
    chk("t4_full_head", 32'(evt_data), 32'h4);
    KEY[0] = 1'b0;
    ticks(12);
    chk("t4_no_ovf", 32'(evt_ovf), 0);
    KEY[0] = 1'b1;
    ticks(12);
    chk("t4_ovf", 32'(evt_ovf), 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t4_ovf_clr", 32'(evt_ovf), 0);
    evt_ready = 1'b1;
    ticks(20);
    chk("t4_drained", 32'(evt_valid), 0);

    // 5: switches held through reset
    rst_n = 1'b0;
    SW = 18'h2A5A5;
    ticks(3);
    rst_n = 1'b1;
    nchg = 0;
    for (int n = 1; n <= 14; n++) begin
      tick();
      if (sw_changed) nchg++;
      if (n == 9) chk("t5_sw9", 32'(sw_level), 0);
      if (n == 10) chk("t5_sw10", 32'(sw_level),
                       32'h2A5A5);
    end
    chk("t5_one_pulse", 32'(nchg), 1);

    // 6: reset with events queued and debounce in flight
    evt_ready = 1'b0;
    KEY = 4'b1000;
    ticks(16);
    KEY[3] = 1'b0;
    ticks(4);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_valid", 32'(evt_valid), 0);
    chk("t6_data", 32'(evt_data), 0);
    chk("t6_lvl", 32'(key_level), 0);
    chk("t6_sw", 32'(sw_level), 0);
    check_all();
    KEY = 4'hF; SW = '0;
    ticks(3);
    rst_n = 1'b1;
    ticks(20);
    chk("t6_no_stale", 32'(evt_valid), 0);

    // randomized phase
    for (int seg = 0; seg < 70; seg++) begin
      KEY = 4'($urandom);
      if ($urandom_range(0, 3) == 0)
        SW = SW ^ 18'($urandom);
      evt_ready = 1'($urandom);
      ovf_clr = ($urandom_range(0, 7) == 0);
      ticks($urandom_range(1, 14));
    end
    evt_ready = 1'b1;
    ovf_clr = 1'b0;
    KEY = 4'hF;
    ticks(40);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
